// File: rtl/bsg_fpu_decoder_pipe_pkg.sv
// Shared types and width helpers for the pipelined IEEE-754 operand unpacker.
package bsg_fpu_decode_pkg;

  typedef struct packed {
    logic sign;
    logic zero;
    logic denormal;
    logic infty;
    logic nan;
    logic sig_nan;
  } fpu_class_s;

  function automatic int unsigned bias_f(input int unsigned e);
    return (32'd1 << (e - 32'd1)) - 32'd1;
  endfunction

  function automatic int unsigned exp_width_f(input int unsigned e);
    return e + 32'd2;
  endfunction

  // A zero mantissa counts m leading zeros, so the count needs m+1 codes.
  function automatic int unsigned lz_width_f(input int unsigned m);
    return (m + 32'd1 <= 32'd2) ? 32'd1 : 32'($clog2(m + 32'd1));
  endfunction

  localparam int unsigned e_default_lp = 8;
  localparam int unsigned m_default_lp = 23;
  localparam int unsigned exp_width_lp = exp_width_f(e_default_lp);
  localparam int unsigned lz_width_lp  = lz_width_f(m_default_lp);

endpackage

// File: rtl/bsg_fpu_decoder_pipe_if.sv
// Valid/ready operand bus and per-lane decode results for bsg_fpu_decoder_pipe.
interface bsg_fpu_decoder_pipe_if #(
  parameter int unsigned e_p   = 8,
  parameter int unsigned m_p   = 23,
  parameter int unsigned els_p = 2
);
  localparam int unsigned w_lp  = e_p + m_p + 1;
  localparam int unsigned ew_lp = e_p + 2;

  logic                      v_i;
  logic                      ready_o;
  logic                      daz_i;
  logic [els_p*w_lp-1:0]     a_i;
  logic                      v_o;
  logic                      yumi_i;
  logic [els_p-1:0]          sign_o;
  logic [els_p-1:0]          zero_o;
  logic [els_p-1:0]          denormal_o;
  logic [els_p-1:0]          infty_o;
  logic [els_p-1:0]          nan_o;
  logic [els_p-1:0]          sig_nan_o;
  logic [els_p*ew_lp-1:0]    exp_o;
  logic [els_p*m_p-1:0]      man_o;

  modport master (
    output v_i, daz_i, a_i, yumi_i,
    input  ready_o, v_o, sign_o, zero_o, denormal_o, infty_o, nan_o, sig_nan_o,
           exp_o, man_o
  );

  modport slave (
    input  v_i, daz_i, a_i, yumi_i,
    output ready_o, v_o, sign_o, zero_o, denormal_o, infty_o, nan_o, sig_nan_o,
           exp_o, man_o
  );
endinterface

// File: rtl/bsg_fpu_decoder_pipe_clz.sv
// Leading-zero count of a mantissa field; an all-zero input returns width_p.
module bsg_fpu_clz #(
  parameter int unsigned width_p    = 23,
  parameter int unsigned lz_width_p = 5
) (
  input  logic [width_p-1:0]    a_i,
  output logic [lz_width_p-1:0] lz_o
);

  // Ascending scan: the highest set bit is the last one to write the result.
  always_comb begin
    lz_o = lz_width_p'(width_p);
    for (int unsigned k = 0; k < width_p; k++) begin
      if (a_i[k]) lz_o = lz_width_p'(width_p - 32'd1 - k);
    end
  end

endmodule

// File: rtl/bsg_fpu_decoder_pipe.sv
// Two-stage multi-lane IEEE-754 unpacker: classify + count leading zeros, then
// normalize subnormals and form the signed unbiased exponent.
module bsg_fpu_decoder_pipe
  import bsg_fpu_decode_pkg::*;
#(
  parameter int unsigned e_p   = 8,
  parameter int unsigned m_p   = 23,
  parameter int unsigned els_p = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  bsg_fpu_decoder_pipe_if.slave io
);

  localparam int unsigned       w_lp       = e_p + m_p + 1;
  localparam int unsigned       ew_lp      = exp_width_f(e_p);
  localparam int unsigned       lzw_lp     = lz_width_f(m_p);
  localparam logic [ew_lp-1:0]  bias_lp    = ew_lp'(bias_f(e_p));
  localparam logic [ew_lp-1:0]  inf_exp_lp = bias_lp + ew_lp'(1);

  logic [els_p-1:0][w_lp-1:0]   a_lanes;
  logic [els_p-1:0][e_p-1:0]    e_in;
  logic [els_p-1:0][m_p-1:0]    m_in;
  logic [els_p-1:0][lzw_lp-1:0] lz_in;
  fpu_class_s [els_p-1:0]       cls_in;
  logic                         ready2;
  logic [m_p-1:0]               man_sh;

  logic                         v1_q, v1_d;
  logic                         daz1_q, daz1_d;
  fpu_class_s [els_p-1:0]       cls1_q, cls1_d;
  logic [els_p-1:0][e_p-1:0]    e1_q, e1_d;
  logic [els_p-1:0][m_p-1:0]    m1_q, m1_d;
  logic [els_p-1:0][lzw_lp-1:0] lz1_q, lz1_d;

  logic                         v2_q, v2_d;
  fpu_class_s [els_p-1:0]       cls2_q, cls2_d;
  logic [els_p-1:0][ew_lp-1:0]  exp2_q, exp2_d;
  logic [els_p-1:0][m_p-1:0]    man2_q, man2_d;

  assign ready2     = ~v2_q | io.yumi_i;
  assign io.ready_o = ~v1_q | ready2;
  assign a_lanes    = io.a_i;

  always_comb begin : classify
    e_in   = '0;
    m_in   = '0;
    cls_in = '0;
    for (int unsigned i = 0; i < els_p; i++) begin
      e_in[i]            = a_lanes[i][m_p +: e_p];
      m_in[i]            = a_lanes[i][m_p-1:0];
      cls_in[i].sign     = a_lanes[i][w_lp-1];
      cls_in[i].zero     = (e_in[i] == '0) & (m_in[i] == '0);
      cls_in[i].denormal = (e_in[i] == '0) & (m_in[i] != '0);
      cls_in[i].infty    = (&e_in[i]) & (m_in[i] == '0);
      cls_in[i].nan      = (&e_in[i]) & (m_in[i] != '0);
      cls_in[i].sig_nan  = cls_in[i].nan & ~m_in[i][m_p-1];
    end
  end

  for (genvar g = 0; g < els_p; g++) begin : g_lane
    bsg_fpu_clz #(
      .width_p    (m_p),
      .lz_width_p (lzw_lp)
    ) clz (
      .a_i  (m_in[g]),
      .lz_o (lz_in[g])
    );

    assign io.sign_o[g]     = cls2_q[g].sign;
    assign io.zero_o[g]     = cls2_q[g].zero;
    assign io.denormal_o[g] = cls2_q[g].denormal;
    assign io.infty_o[g]    = cls2_q[g].infty;
    assign io.nan_o[g]      = cls2_q[g].nan;
    assign io.sig_nan_o[g]  = cls2_q[g].sig_nan;
  end

  assign io.v_o   = v2_q;
  assign io.exp_o = exp2_q;
  assign io.man_o = man2_q;

  always_comb begin : stage1_next
    v1_d   = v1_q;
    daz1_d = daz1_q;
    cls1_d = cls1_q;
    e1_d   = e1_q;
    m1_d   = m1_q;
    lz1_d  = lz1_q;
    if (io.ready_o) begin
      v1_d = io.v_i;
      if (io.v_i) begin
        daz1_d = io.daz_i;
        cls1_d = cls_in;
        e1_d   = e_in;
        m1_d   = m_in;
        lz1_d  = lz_in;
      end
    end
  end

  // DAZ is resolved here so stage 1 keeps the raw class; a flushed subnormal
  // reports both denormal and zero.
  always_comb begin : stage2_next
    v2_d   = v2_q;
    cls2_d = cls2_q;
    exp2_d = exp2_q;
    man2_d = man2_q;
    man_sh = '0;
    if (ready2) begin
      v2_d = v1_q;
      if (v1_q) begin
        for (int unsigned i = 0; i < els_p; i++) begin
          cls2_d[i]      = cls1_q[i];
          cls2_d[i].zero = cls1_q[i].zero | (cls1_q[i].denormal & daz1_q);
          man_sh         = m1_q[i] << lz1_q[i];
          if (cls2_d[i].zero) begin
            exp2_d[i] = '0;
            man2_d[i] = '0;
          end else if (cls1_q[i].denormal) begin
            exp2_d[i] = '0 - bias_lp - ew_lp'(lz1_q[i]);
            man2_d[i] = man_sh << 1;
          end else if (cls1_q[i].infty | cls1_q[i].nan) begin
            exp2_d[i] = inf_exp_lp;
            man2_d[i] = m1_q[i];
          end else begin
            exp2_d[i] = ew_lp'(e1_q[i]) - bias_lp;
            man2_d[i] = m1_q[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v1_q   <= 1'b0;
      daz1_q <= 1'b0;
      cls1_q <= '0;
      e1_q   <= '0;
      m1_q   <= '0;
      lz1_q  <= '0;
      v2_q   <= 1'b0;
      cls2_q <= '0;
      exp2_q <= '0;
      man2_q <= '0;
    end else begin
      v1_q   <= v1_d;
      daz1_q <= daz1_d;
      cls1_q <= cls1_d;
      e1_q   <= e1_d;
      m1_q   <= m1_d;
      lz1_q  <= lz1_d;
      v2_q   <= v2_d;
      cls2_q <= cls2_d;
      exp2_q <= exp2_d;
      man2_q <= man2_d;
    end
  end

endmodule

// File: tb/tb_bsg_fpu_decoder_pipe.sv
// Directed bench for bsg_fpu_decoder_pipe: f32 single lane and fp16 four lanes.
module tb_bsg_fpu_decoder_pipe;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  bsg_fpu_decoder_pipe_if #(.e_p(8), .m_p(23), .els_p(1)) io32 ();
  bsg_fpu_decoder_pipe_if #(.e_p(5), .m_p(10), .els_p(4)) io16 ();

  bsg_fpu_decoder_pipe #(.e_p(8), .m_p(23), .els_p(1)) dut32 (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .io        (io32.slave)
  );

  bsg_fpu_decoder_pipe #(.e_p(5), .m_p(10), .els_p(4)) dut16 (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .io        (io16.slave)
  );

  function automatic logic [5:0] flags32();
    return {io32.sign_o[0], io32.zero_o[0], io32.denormal_o[0],
            io32.infty_o[0], io32.nan_o[0], io32.sig_nan_o[0]};
  endfunction

  function automatic logic [5:0] flags16(input int l);
    return {io16.sign_o[l], io16.zero_o[l], io16.denormal_o[l],
            io16.infty_o[l], io16.nan_o[l], io16.sig_nan_o[l]};
  endfunction

  // One transaction into an empty f32 pipe; returns two edges after accept.
  task automatic xact32(input logic [31:0] a, input logic daz);
    io32.v_i    = 1'b1;
    io32.a_i    = a;
    io32.daz_i  = daz;
    io32.yumi_i = 1'b0;
    @(posedge clk); #1;
    io32.v_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pop32();
    io32.yumi_i = io32.v_o;
    @(posedge clk); #1;
    io32.yumi_i = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (io32.v_o !== 1'b0) begin n_fail++; $display("FAIL reset_v_o32: got %b expected 0", io32.v_o); end
    n_checks++;
    if (io32.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready32: got %b expected 1", io32.ready_o); end
    n_checks++;
    if (flags32() !== 6'b0) begin n_fail++; $display("FAIL reset_flags32: got %b expected 0", flags32()); end
    n_checks++;
    if (io32.exp_o !== 10'h0) begin n_fail++; $display("FAIL reset_exp32: got %h expected 0", io32.exp_o); end
    n_checks++;
    if (io32.man_o !== 23'h0) begin n_fail++; $display("FAIL reset_man32: got %h expected 0", io32.man_o); end
    n_checks++;
    if (io16.v_o !== 1'b0 || io16.ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_hs16: got v_o=%b ready_o=%b expected 0/1", io16.v_o, io16.ready_o);
    end
    n_checks++;
    if ({io16.sign_o, io16.zero_o, io16.denormal_o, io16.infty_o, io16.nan_o, io16.sig_nan_o,
         io16.exp_o, io16.man_o} !== '0) begin
      n_fail++; $display("FAIL reset_data16: got exp=%h man=%h expected 0", io16.exp_o, io16.man_o);
    end
  endtask

  task automatic test_normal();
    logic [31:0] a_t [4] = '{32'h3F800000, 32'hC0400000, 32'h7F7FFFFF, 32'h00800000};
    logic [5:0]  f_t [4] = '{6'b000000, 6'b100000, 6'b000000, 6'b000000};
    logic [9:0]  e_t [4] = '{10'h000, 10'h001, 10'h07F, 10'h382};
    logic [22:0] m_t [4] = '{23'h000000, 23'h400000, 23'h7FFFFF, 23'h000000};
    for (int i = 0; i < 4; i++) begin
      xact32(a_t[i], 1'b0);
      n_checks++;
      if (io32.v_o !== 1'b1) begin n_fail++; $display("FAIL normal_v_o[%0d]: got %b expected 1", i, io32.v_o); end
      n_checks++;
      if (flags32() !== f_t[i]) begin n_fail++; $display("FAIL normal_flags[%0d]: got %b expected %b", i, flags32(), f_t[i]); end
      n_checks++;
      if (io32.exp_o !== e_t[i]) begin n_fail++; $display("FAIL normal_exp[%0d]: got %h expected %h", i, io32.exp_o, e_t[i]); end
      n_checks++;
      if (io32.man_o !== m_t[i]) begin n_fail++; $display("FAIL normal_man[%0d]: got %h expected %h", i, io32.man_o, m_t[i]); end
      pop32();
    end
  endtask

  task automatic test_subnormal_daz();
    logic [31:0] a_t [6] = '{32'h00000001, 32'h00400000, 32'h007FFFFF,
                             32'h00000001, 32'h00400000, 32'h80000001};
    logic        d_t [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [5:0]  f_t [6] = '{6'b001000, 6'b001000, 6'b001000, 6'b011000, 6'b011000, 6'b111000};
    logic [9:0]  e_t [6] = '{10'h36B, 10'h381, 10'h381, 10'h000, 10'h000, 10'h000};
    logic [22:0] m_t [6] = '{23'h0, 23'h0, 23'h7FFFFE, 23'h0, 23'h0, 23'h0};
    for (int i = 0; i < 6; i++) begin
      xact32(a_t[i], d_t[i]);
      n_checks++;
      if (io32.v_o !== 1'b1) begin n_fail++; $display("FAIL subn_v_o[%0d]: got %b expected 1", i, io32.v_o); end
      n_checks++;
      if (flags32() !== f_t[i]) begin n_fail++; $display("FAIL subn_flags[%0d]: got %b expected %b", i, flags32(), f_t[i]); end
      n_checks++;
      if (io32.exp_o !== e_t[i]) begin n_fail++; $display("FAIL subn_exp[%0d]: got %h expected %h", i, io32.exp_o, e_t[i]); end
      n_checks++;
      if (io32.man_o !== m_t[i]) begin n_fail++; $display("FAIL subn_man[%0d]: got %h expected %h", i, io32.man_o, m_t[i]); end
      pop32();
    end
  endtask

  task automatic test_special();
    logic [31:0] a_t [6] = '{32'h7F800000, 32'hFF800000, 32'h7FC00001,
                             32'h7F800001, 32'h00000000, 32'h80000000};
    logic        d_t [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [5:0]  f_t [6] = '{6'b000100, 6'b100100, 6'b000010, 6'b000011, 6'b010000, 6'b110000};
    logic [9:0]  e_t [6] = '{10'h080, 10'h080, 10'h080, 10'h080, 10'h000, 10'h000};
    logic [22:0] m_t [6] = '{23'h0, 23'h0, 23'h400001, 23'h000001, 23'h0, 23'h0};
    for (int i = 0; i < 6; i++) begin
      xact32(a_t[i], d_t[i]);
      n_checks++;
      if (io32.v_o !== 1'b1) begin n_fail++; $display("FAIL special_v_o[%0d]: got %b expected 1", i, io32.v_o); end
      n_checks++;
      if (flags32() !== f_t[i]) begin n_fail++; $display("FAIL special_flags[%0d]: got %b expected %b", i, flags32(), f_t[i]); end
      n_checks++;
      if (io32.exp_o !== e_t[i]) begin n_fail++; $display("FAIL special_exp[%0d]: got %h expected %h", i, io32.exp_o, e_t[i]); end
      n_checks++;
      if (io32.man_o !== m_t[i]) begin n_fail++; $display("FAIL special_man[%0d]: got %h expected %h", i, io32.man_o, m_t[i]); end
      pop32();
    end
  endtask

  // Transaction k carries E=127+k, M=3k+1, so it must emerge as exp=k, man=3k+1.
  task automatic test_back_to_back();
    for (int n = 1; n <= 11; n++) begin
      io32.yumi_i = io32.v_o;
      io32.daz_i  = 1'b0;
      if (n <= 8) begin
        io32.v_i = 1'b1;
        io32.a_i = {1'b0, 8'(127 + n - 1), 23'((n - 1) * 3 + 1)};
      end else begin
        io32.v_i = 1'b0;
      end
      @(posedge clk); #1;
      if (n >= 2 && n <= 9) begin
        n_checks++;
        if (io32.v_o !== 1'b1) begin n_fail++; $display("FAIL b2b_v_o[%0d]: got %b expected 1", n, io32.v_o); end
        n_checks++;
        if (io32.exp_o !== 10'(n - 2)) begin n_fail++; $display("FAIL b2b_exp[%0d]: got %h expected %h", n, io32.exp_o, 10'(n - 2)); end
        n_checks++;
        if (io32.man_o !== 23'((n - 2) * 3 + 1)) begin
          n_fail++; $display("FAIL b2b_man[%0d]: got %h expected %h", n, io32.man_o, 23'((n - 2) * 3 + 1));
        end
      end else begin
        n_checks++;
        if (io32.v_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle[%0d]: got %b expected 0", n, io32.v_o); end
      end
    end
    io32.yumi_i = 1'b0;
  endtask

  // Stall item k: E=100+k, M=k+5 -> exp=k-27, man=k+5.
  task automatic test_stall();
    int acc = 0;
    int low = 0;
    int got = 0;
    for (int c = 0; c < 4; c++) begin
      io32.yumi_i = 1'b0;
      io32.daz_i  = 1'b0;
      io32.v_i    = 1'b1;
      io32.a_i    = {1'b0, 8'(100 + acc), 23'(acc + 5)};
      #1;
      if (io32.ready_o) acc++; else low++;
      @(posedge clk); #1;
      if (c >= 1) begin
        n_checks++;
        if (io32.v_o !== 1'b1 || io32.exp_o !== 10'h3E5 || io32.man_o !== 23'd5) begin
          n_fail++; $display("FAIL stall_hold[%0d]: got v=%b exp=%h man=%h expected 1/3e5/5", c, io32.v_o, io32.exp_o, io32.man_o);
        end
      end
    end
    n_checks++;
    if (acc != 2) begin n_fail++; $display("FAIL stall_accepts: got %0d expected 2", acc); end
    n_checks++;
    if (low != 2) begin n_fail++; $display("FAIL stall_ready_low: got %0d expected 2", low); end
    for (int c = 0; c < 10; c++) begin
      io32.yumi_i = io32.v_o;
      if (io32.v_o) begin
        n_checks++;
        if (io32.exp_o !== 10'(100 + got - 127) || io32.man_o !== 23'(got + 5)) begin
          n_fail++; $display("FAIL stall_order[%0d]: got exp=%h man=%h expected %h/%h", got, io32.exp_o, io32.man_o,
                             10'(100 + got - 127), 23'(got + 5));
        end
        got++;
      end
      io32.v_i = (acc < 4);
      io32.a_i = {1'b0, 8'(100 + acc), 23'(acc + 5)};
      #1;
      if (io32.v_i && io32.ready_o) acc++;
      @(posedge clk); #1;
    end
    io32.v_i    = 1'b0;
    io32.yumi_i = 1'b0;
    n_checks++;
    if (got != 4) begin n_fail++; $display("FAIL stall_count: got %0d expected 4", got); end
    n_checks++;
    if (io32.v_o !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %b expected 0", io32.v_o); end
  endtask

  task automatic test_reset_midstall();
    io32.yumi_i = 1'b0;
    io32.daz_i  = 1'b0;
    io32.v_i    = 1'b1;
    io32.a_i    = 32'h40000000;
    @(posedge clk); #1;
    io32.a_i    = 32'h40800000;
    @(posedge clk); #1;
    io32.v_i    = 1'b0;
    n_checks++;
    if (io32.v_o !== 1'b1 || io32.ready_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_full: got v_o=%b ready_o=%b expected 1/0", io32.v_o, io32.ready_o);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (io32.v_o !== 1'b0 || io32.ready_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_async_hs: got v_o=%b ready_o=%b expected 0/1", io32.v_o, io32.ready_o);
    end
    n_checks++;
    if (flags32() !== 6'b0 || io32.exp_o !== 10'h0 || io32.man_o !== 23'h0) begin
      n_fail++; $display("FAIL rst_async_data: got flags=%b exp=%h man=%h expected 0", flags32(), io32.exp_o, io32.man_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (io32.v_o !== 1'b0 || io32.ready_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_edge_hs: got v_o=%b ready_o=%b expected 0/1", io32.v_o, io32.ready_o);
    end
    reset_n = 1'b1;
    xact32(32'h40400000, 1'b0);
    n_checks++;
    if (io32.v_o !== 1'b1 || io32.exp_o !== 10'h001 || io32.man_o !== 23'h400000 || flags32() !== 6'b0) begin
      n_fail++; $display("FAIL rst_after: got v=%b exp=%h man=%h flags=%b expected 1/001/400000/0",
                         io32.v_o, io32.exp_o, io32.man_o, flags32());
    end
    pop32();
    n_checks++;
    if (io32.v_o !== 1'b0) begin n_fail++; $display("FAIL rst_single: got %b expected 0", io32.v_o); end
  endtask

  task automatic test_fp16_lanes();
    logic [15:0] a_t [3][4] = '{'{16'h3C00, 16'h0001, 16'hFC00, 16'h7D01},
                                '{16'h8000, 16'h0200, 16'h0155, 16'h7BFF},
                                '{16'h0155, 16'h8001, 16'h0400, 16'h7E00}};
    logic        d_t [3]    = '{1'b0, 1'b0, 1'b1};
    logic [5:0]  f_t [3][4] = '{'{6'b000000, 6'b001000, 6'b100100, 6'b000011},
                                '{6'b110000, 6'b001000, 6'b001000, 6'b000000},
                                '{6'b011000, 6'b111000, 6'b000000, 6'b000010}};
    logic [6:0]  e_t [3][4] = '{'{7'h00, 7'h68, 7'h10, 7'h10},
                                '{7'h00, 7'h71, 7'h70, 7'h0F},
                                '{7'h00, 7'h00, 7'h72, 7'h10}};
    logic [9:0]  m_t [3][4] = '{'{10'h000, 10'h000, 10'h000, 10'h101},
                                '{10'h000, 10'h000, 10'h154, 10'h3FF},
                                '{10'h000, 10'h000, 10'h000, 10'h200}};
    for (int t = 0; t < 3; t++) begin
      io16.v_i    = 1'b1;
      io16.daz_i  = d_t[t];
      io16.yumi_i = 1'b0;
      for (int l = 0; l < 4; l++) io16.a_i[16*l +: 16] = a_t[t][l];
      @(posedge clk); #1;
      io16.v_i = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (io16.v_o !== 1'b1) begin n_fail++; $display("FAIL fp16_v_o[%0d]: got %b expected 1", t, io16.v_o); end
      for (int l = 0; l < 4; l++) begin
        n_checks++;
        if (flags16(l) !== f_t[t][l]) begin
          n_fail++; $display("FAIL fp16_flags[%0d][%0d]: got %b expected %b", t, l, flags16(l), f_t[t][l]);
        end
        n_checks++;
        if (io16.exp_o[7*l +: 7] !== e_t[t][l]) begin
          n_fail++; $display("FAIL fp16_exp[%0d][%0d]: got %h expected %h", t, l, io16.exp_o[7*l +: 7], e_t[t][l]);
        end
        n_checks++;
        if (io16.man_o[10*l +: 10] !== m_t[t][l]) begin
          n_fail++; $display("FAIL fp16_man[%0d][%0d]: got %h expected %h", t, l, io16.man_o[10*l +: 10], m_t[t][l]);
        end
      end
      io16.yumi_i = 1'b1;
      @(posedge clk); #1;
      io16.yumi_i = 1'b0;
    end
  endtask

  initial begin
    io32.v_i = 1'b0; io32.daz_i = 1'b0; io32.a_i = '0; io32.yumi_i = 1'b0;
    io16.v_i = 1'b0; io16.daz_i = 1'b0; io16.a_i = '0; io16.yumi_i = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    test_normal();
    test_subnormal_daz();
    test_special();
    test_back_to_back();
    test_stall();
    test_reset_midstall();
    test_fp16_lanes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
